// File: rtl/aes_pkg.sv
// Shared types and round-count constants for the AES round controller.
package aes_pkg;

   typedef enum logic [1:0] {
      KS128   = 2'b00,
      KS192   = 2'b01,
      KS256   = 2'b10,
      KS_RSVD = 2'b11
   } key_size_e;

   localparam int NR_128 = 10;
   localparam int NR_192 = 12;
   localparam int NR_256 = 14;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } ctrl_state_e;

   // Reserved encoding maps to 0 so callers can treat it as "no rounds".
   function automatic int nr_of(input key_size_e ks);
      case (ks)
         KS128:   return NR_128;
         KS192:   return NR_192;
         KS256:   return NR_256;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/aes_round_cnt.sv
// Loadable round counter with terminal-count compare; saturates at nr.
module aes_round_cnt #(
   parameter int RW = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr,
   input  logic          start,
   input  logic          inc,
   input  logic [RW-1:0] nr,
   output logic [RW-1:0] idx,
   output logic          last
);

   always_ff @(posedge clk_i) begin
      if (rst_i || clr)
         idx <= '0;
      else if (start)
         idx <= RW'(1);
      else if (inc && idx != nr)
         idx <= idx + RW'(1);
   end

   assign last = (idx == nr);

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer (AES-128/192/256, enc/dec).
// Optional abort input enabled by defining AES_CTRL_ABORT_EN.
module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int MAX_NR = 14,
   parameter int RW     = $clog2(MAX_NR + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          valid_i,
   output logic          ready_o,
   input  logic [1:0]    key_size_i,
   input  logic          decrypt_i,
   output logic          round0_sel_o,
   output logic          state_en_o,
   output logic [RW-1:0] round_idx_o,
   output logic [RW-1:0] key_idx_o,
   output logic          final_round_o,
   output logic          valid_o,
   input  logic          ready_i,
   output logic          err_o
`ifdef AES_CTRL_ABORT_EN
   ,
   input  logic          abort_i
`endif
);

   ctrl_state_e   state, nxt;
   logic [RW-1:0] nr_q;
   logic          dec_q;
   logic [RW-1:0] nr_in;
   logic          legal;
   logic          abort;
   logic          latch;
   logic          cnt_clr, cnt_start, cnt_inc;
   logic [RW-1:0] idx;
   logic          last;
   key_size_e     ks;

`ifdef AES_CTRL_ABORT_EN
   assign abort = abort_i;
`else
   assign abort = 1'b0;
`endif

   assign ks    = key_size_e'(key_size_i);
   assign nr_in = RW'(nr_of(ks));
   assign legal = (ks != KS_RSVD) && (nr_of(ks) <= MAX_NR);

   aes_round_cnt #(.RW(RW)) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr   (cnt_clr),
      .start (cnt_start),
      .inc   (cnt_inc),
      .nr    (nr_q),
      .idx   (idx),
      .last  (last)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         nr_q  <= '0;
         dec_q <= 1'b0;
      end else begin
         state <= nxt;
         if (latch) begin
            nr_q  <= nr_in;
            dec_q <= decrypt_i;
         end
      end
   end

   always_comb begin
      nxt          = state;
      ready_o      = 1'b0;
      round0_sel_o = 1'b0;
      state_en_o   = 1'b0;
      valid_o      = 1'b0;
      err_o        = 1'b0;
      latch        = 1'b0;
      cnt_clr      = 1'b0;
      cnt_start    = 1'b0;
      cnt_inc      = 1'b0;
      key_idx_o    = dec_q ? (nr_q - idx) : idx;
      case (state)
         IDLE: begin
            ready_o   = 1'b1;
            key_idx_o = '0;
            if (valid_i) begin
               if (legal) begin
                  round0_sel_o = 1'b1;
                  state_en_o   = 1'b1;
                  latch        = 1'b1;
                  cnt_start    = 1'b1;
                  key_idx_o    = decrypt_i ? nr_in : '0;
                  nxt          = RUN;
               end else begin
                  err_o = 1'b1;
               end
            end
         end
         RUN: begin
            state_en_o = 1'b1;
            if (abort) begin
               cnt_clr = 1'b1;
               nxt     = IDLE;
            end else if (last) begin
               nxt = DONE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         DONE: begin
            valid_o = 1'b1;
            // A completing handshake and an abort both land in IDLE with a cleared counter.
            if (ready_i || abort) begin
               cnt_clr = 1'b1;
               nxt     = IDLE;
            end
         end
         default: begin
            cnt_clr = 1'b1;
            nxt     = IDLE;
         end
      endcase
   end

   assign round_idx_o   = idx;
   assign final_round_o = (state == RUN) && last;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: full-size instance plus a MAX_NR=10 instance.
module tb_aes_round_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid, dec, rdy;
   logic [1:0] ks;
   logic       ready, r0, en, fin, vout, err;
   logic [3:0] ridx, kidx;
`ifdef AES_CTRL_ABORT_EN
   logic       abort;
`endif

   logic       valid10;
   logic [1:0] ks10;
   logic       ready10, r0_10, en10, fin10, vout10, err10;
   logic [3:0] ridx10, kidx10;

   logic [5:0] flags, flags10;
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   assign flags   = {r0, en, ready, vout, fin, err};
   assign flags10 = {r0_10, en10, ready10, vout10, fin10, err10};

   aes_round_ctrl #(.MAX_NR(14)) u_dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .valid_i       (valid),
      .ready_o       (ready),
      .key_size_i    (ks),
      .decrypt_i     (dec),
      .round0_sel_o  (r0),
      .state_en_o    (en),
      .round_idx_o   (ridx),
      .key_idx_o     (kidx),
      .final_round_o (fin),
      .valid_o       (vout),
      .ready_i       (rdy),
      .err_o         (err)
`ifdef AES_CTRL_ABORT_EN
      ,
      .abort_i       (abort)
`endif
   );

   aes_round_ctrl #(.MAX_NR(10)) u_dut10 (
      .clk_i         (clk),
      .rst_i         (rst),
      .valid_i       (valid10),
      .ready_o       (ready10),
      .key_size_i    (ks10),
      .decrypt_i     (1'b0),
      .round0_sel_o  (r0_10),
      .state_en_o    (en10),
      .round_idx_o   (ridx10),
      .key_idx_o     (kidx10),
      .final_round_o (fin10),
      .valid_o       (vout10),
      .ready_i       (1'b1),
      .err_o         (err10)
`ifdef AES_CTRL_ABORT_EN
      ,
      .abort_i       (1'b0)
`endif
   );

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; valid = 0; dec = 0; rdy = 0; ks = 2'b00; valid10 = 0; ks10 = 2'b00;
`ifdef AES_CTRL_ABORT_EN
      abort = 0;
`endif
      cyc(); cyc(); #1;
      n_cmp++;
      if (flags !== 6'b001000 || ridx !== 4'd0 || kidx !== 4'd0) begin
         n_bad++;
         $display("FAIL reset flags=%b idx=%0d key=%0d want flags=001000 idx=0 key=0", flags, ridx, kidx);
      end
      n_cmp++;
      if (flags10 !== 6'b001000 || ridx10 !== 4'd0) begin
         n_bad++;
         $display("FAIL reset10 flags=%b idx=%0d want flags=001000 idx=0", flags10, ridx10);
      end
      rst = 1'b0;
   endtask

   task automatic test_enc128();
      cyc(); valid = 1; ks = 2'b00; dec = 0; rdy = 1; #1;
      n_cmp++;
      if (flags !== 6'b111000 || ridx !== 4'd0 || kidx !== 4'd0) begin
         n_bad++;
         $display("FAIL enc128_accept flags=%b idx=%0d key=%0d want 111000/0/0", flags, ridx, kidx);
      end
      for (int r = 1; r <= 10; r++) begin
         cyc();
         if (r == 1) begin valid = 0; ks = 2'b11; dec = 1; end  // latched values must win
         #1;
         n_cmp++;
         if (flags !== {4'b0100, (r == 10), 1'b0} || ridx !== 4'(r) || kidx !== 4'(r)) begin
            n_bad++;
            $display("FAIL enc128_round%0d flags=%b idx=%0d key=%0d want idx=key=%0d", r, flags, ridx, kidx, r);
         end
      end
      cyc(); #1;
      n_cmp++;
      if (flags !== 6'b000100 || ridx !== 4'd10) begin
         n_bad++;
         $display("FAIL enc128_done flags=%b idx=%0d want 000100/10", flags, ridx);
      end
      cyc(); #1;
      n_cmp++;
      if (flags !== 6'b001000 || ridx !== 4'd0) begin
         n_bad++;
         $display("FAIL enc128_idle flags=%b idx=%0d want 001000/0", flags, ridx);
      end
      ks = 2'b00; dec = 0;
   endtask

   task automatic test_dec256();
      cyc(); valid = 1; ks = 2'b10; dec = 1; rdy = 1; #1;
      n_cmp++;
      if (flags !== 6'b111000 || kidx !== 4'd14) begin
         n_bad++;
         $display("FAIL dec256_accept flags=%b key=%0d want 111000/14", flags, kidx);
      end
      for (int r = 1; r <= 14; r++) begin
         cyc();
         if (r == 1) begin valid = 0; dec = 0; ks = 2'b00; end
         #1;
         n_cmp++;
         if (flags !== {4'b0100, (r == 14), 1'b0} || ridx !== 4'(r) || kidx !== 4'(14 - r)) begin
            n_bad++;
            $display("FAIL dec256_round%0d flags=%b idx=%0d key=%0d want key=%0d", r, flags, ridx, kidx, 14 - r);
         end
      end
      cyc(); #1;
      n_cmp++;
      if (flags !== 6'b000100 || ridx !== 4'd14) begin
         n_bad++;
         $display("FAIL dec256_done flags=%b idx=%0d want 000100/14", flags, ridx);
      end
      cyc(); #1;
      n_cmp++;
      if (flags !== 6'b001000) begin
         n_bad++;
         $display("FAIL dec256_idle flags=%b want 001000", flags);
      end
   endtask

   task automatic test_backpressure();
      cyc(); valid = 1; ks = 2'b01; dec = 0; rdy = 0; #1;
      n_cmp++;
      if (flags !== 6'b111000) begin
         n_bad++;
         $display("FAIL bp_accept flags=%b want 111000", flags);
      end
      // valid_i left high while busy must be ignored
      for (int r = 1; r <= 12; r++) begin
         cyc(); #1;
         n_cmp++;
         if (flags !== {4'b0100, (r == 12), 1'b0} || ridx !== 4'(r)) begin
            n_bad++;
            $display("FAIL bp_round%0d flags=%b idx=%0d want idx=%0d", r, flags, ridx, r);
         end
      end
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (i == 0) valid = 0;
         if (i == 5) rdy = 1;
         #1;
         n_cmp++;
         if (flags !== 6'b000100 || ridx !== 4'd12) begin
            n_bad++;
            $display("FAIL bp_hold%0d flags=%b idx=%0d want 000100/12", i, flags, ridx);
         end
      end
      cyc(); #1;
      n_cmp++;
      if (flags !== 6'b001000 || ridx !== 4'd0) begin
         n_bad++;
         $display("FAIL bp_idle flags=%b idx=%0d want 001000/0", flags, ridx);
      end
   endtask

   task automatic test_illegal();
      cyc(); valid = 1; ks = 2'b11; #1;
      n_cmp++;
      if (flags !== 6'b001001) begin
         n_bad++;
         $display("FAIL rsvd_err flags=%b want 001001", flags);
      end
      cyc(); valid = 0; ks = 2'b00; #1;
      n_cmp++;
      if (flags !== 6'b001000 || ridx !== 4'd0) begin
         n_bad++;
         $display("FAIL rsvd_after flags=%b idx=%0d want 001000/0", flags, ridx);
      end
      cyc(); valid10 = 1; ks10 = 2'b01; #1;
      n_cmp++;
      if (flags10 !== 6'b001001) begin
         n_bad++;
         $display("FAIL max10_192_err flags=%b want 001001", flags10);
      end
      cyc(); ks10 = 2'b00; #1;
      n_cmp++;
      if (flags10 !== 6'b111000) begin
         n_bad++;
         $display("FAIL max10_128_accept flags=%b want 111000", flags10);
      end
      cyc(); valid10 = 0; #1;
      n_cmp++;
      if (flags10 !== 6'b010000 || ridx10 !== 4'd1) begin
         n_bad++;
         $display("FAIL max10_run flags=%b idx=%0d want 010000/1", flags10, ridx10);
      end
   endtask

   task automatic test_reset_mid_run();
      cyc(); valid = 1; ks = 2'b00; dec = 0; rdy = 1; #1;
      for (int r = 1; r <= 5; r++) begin
         cyc(); valid = 0; #1;
         n_cmp++;
         if (ridx !== 4'(r)) begin
            n_bad++;
            $display("FAIL rst_run_round%0d idx=%0d want %0d", r, ridx, r);
         end
      end
      rst = 1;
      cyc(); #1;
      n_cmp++;
      if (flags !== 6'b001000 || ridx !== 4'd0 || kidx !== 4'd0) begin
         n_bad++;
         $display("FAIL rst_mid flags=%b idx=%0d key=%0d want 001000/0/0", flags, ridx, kidx);
      end
      rst = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(); #1;
         n_cmp++;
         if (flags !== 6'b001000) begin
            n_bad++;
            $display("FAIL rst_no_valid%0d flags=%b want 001000", i, flags);
         end
      end
      test_enc128();
   endtask

`ifdef AES_CTRL_ABORT_EN
   task automatic test_abort();
      cyc(); valid = 1; ks = 2'b00; dec = 0; rdy = 1; #1;
      for (int r = 1; r <= 7; r++) begin
         cyc(); valid = 0; #1;
      end
      n_cmp++;
      if (ridx !== 4'd7) begin
         n_bad++;
         $display("FAIL abort_round7 idx=%0d want 7", ridx);
      end
      abort = 1;
      cyc(); #1;
      n_cmp++;
      if (flags !== 6'b001000 || ridx !== 4'd0) begin
         n_bad++;
         $display("FAIL abort_idle flags=%b idx=%0d want 001000/0", flags, ridx);
      end
      cyc(); valid = 1; #1;
      n_cmp++;
      if (flags !== 6'b111000) begin
         n_bad++;
         $display("FAIL abort_with_valid flags=%b want 111000", flags);
      end
      cyc(); valid = 0; abort = 0; #1;
      n_cmp++;
      if (flags !== 6'b010000 || ridx !== 4'd1) begin
         n_bad++;
         $display("FAIL abort_accepted flags=%b idx=%0d want 010000/1", flags, ridx);
      end
      repeat (11) cyc();
      #1;
      n_cmp++;
      if (flags !== 6'b001000) begin
         n_bad++;
         $display("FAIL abort_drain flags=%b want 001000", flags);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_enc128();
      test_dec256();
      test_backpressure();
      test_illegal();
      test_reset_mid_run();
`ifdef AES_CTRL_ABORT_EN
      test_abort();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Parametrised round-sequencing controller for the iterative AES datapath. It supersedes the fixed 10-round, single-mode controller.
- Supports AES-128/192/256 (Nr = 10/12/14), selected per block at accept time, in encrypt or decrypt mode.
- Uses a ready/valid handshake on input and a held ready/valid handshake on output.
- Drives the round datapath, the round-key selection and the final-round MixColumns bypass.

Parameters:
- MAX_NR, 14, largest supported round count; legal values 10, 12, 14. Modes above MAX_NR are rejected.
- RW, $clog2(MAX_NR+1), width of the round index; derived, do not override.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- valid_i  in  1  input block and key are present
- ready_o  out  1  controller can accept a block
- key_size_i  in  2  00=128, 01=192, 10=256, 11=reserved
- decrypt_i  in  1  0=encrypt, 1=decrypt; sampled at accept
- round0_sel_o  out  1  datapath loads the input block and performs the initial AddRoundKey
- state_en_o  out  1  state register write enable
- round_idx_o  out  RW  current round number, 0..Nr
- key_idx_o  out  RW  round-key index; equals round_idx_o for encrypt, Nr-round_idx_o for decrypt
- final_round_o  out  1  round_idx_o==Nr; datapath bypasses (Inv)MixColumns
- valid_o  out  1  result block valid
- ready_i  in  1  downstream accepts the result
- err_o  out  1  one-cycle pulse when a block is rejected (reserved or unsupported key size)

Behaviour:
- States: IDLE, RUN, DONE. Reset puts the controller in IDLE.
- Reset values: ready_o=1; round_idx_o=0; key_idx_o=0; all other outputs 0. Reset has priority over every other event.
- IDLE:
  - ready_o=1.
  - On valid_i=1 with a legal key size and Nr<=MAX_NR (the accept cycle):
    - Latch nr_q (10/12/14) and dec_q.
    - Drive round0_sel_o=1, state_en_o=1, round_idx_o=0.
    - Drive key_idx_o=0 for encrypt, or Nr for decrypt.
    - Next state is RUN with the counter at 1.
  - On valid_i=1 with an illegal key size:
    - Assert err_o for one cycle, stay in IDLE, raise no enables.
- RUN:
  - ready_o=0, state_en_o=1, round0_sel_o=0.
  - round_idx_o counts 1..nr_q, one per cycle. key_idx_o follows the decrypt mapping.
  - final_round_o=1 exactly when round_idx_o==nr_q.
  - After the cycle with round_idx_o==nr_q, next state is DONE.
- DONE:
  - valid_o=1, state_en_o=0.
  - round_idx_o holds nr_q so the datapath output stays stable.
  - valid_o stays high until ready_i=1. The handshake cycle returns the state to IDLE and clears the counter to 0.
  - No new block is accepted in DONE; ready_o=0.
- Latency: accept in cycle T -> valid_o first high in cycle T+Nr+1.
- Throughput: one block per Nr+2 cycles when ready_i is held at 1.
- Inputs key_size_i and decrypt_i may change after accept without effect; they are latched.
- valid_i asserted while busy is ignored. The upstream block must hold it until it sees ready_o.
- ready_i while not in DONE is ignored.
- Reset asserted mid-RUN or in DONE aborts the block. No valid_o is produced for that block.
- The counter never exceeds nr_q; there is no wrap-around.

Optional Feature:
- AES_CTRL_ABORT_EN
- When defined:
  - Adds input abort_i (1 bit).
  - abort_i=1 in RUN or DONE returns the controller to IDLE on the next edge, with the counter cleared and valid_o dropped. No result is produced.
  - abort_i in IDLE has no effect. If abort_i and valid_i arrive in the same IDLE cycle, the accept proceeds.
  - abort_i in the DONE cycle where ready_i=1: the handshake completes normally.
- When undefined: no abort_i port; behaviour is exactly as above.

Decomposition:
- Package aes_pkg holds:
  - the key_size_e enum (KS128, KS192, KS256, KS_RSVD)
  - constants NR_128=10, NR_192=12, NR_256=14
  - the ctrl_state_e enum (IDLE, RUN, DONE)
  - function nr_of(key_size_e) returning the round count
- One natural sub-module: aes_round_cnt. It is the loadable RW-bit up-counter with a terminal-count compare against nr_q, and it produces round_idx and the final flag. The FSM and key_idx mapping stay in the top module.

Test Plan:
- Encrypt AES-128: valid_i=1, key_size_i=00, decrypt_i=0, ready_i=1 at T.
  - Expect round0_sel_o=1 at T.
  - Expect round_idx_o 1..10 in T+1..T+10, with final_round_o only at T+10.
  - Expect valid_o at T+11 and ready_o=1 at T+12.
- Decrypt AES-256: key_size_i=10, decrypt_i=1.
  - Expect key_idx_o sequence 14,13,...,0 across T..T+14.
  - Expect valid_o at T+15.
- Backpressure: AES-192 with ready_i=0 for 5 cycles after DONE.
  - Expect valid_o held 6 cycles, round_idx_o=12 held, ready_o=0 throughout.
  - Expect IDLE one cycle after ready_i=1.
- Illegal and unsupported modes:
  - key_size_i=11 -> err_o pulse, ready_o stays 1, no state_en_o.
  - With MAX_NR=10, key_size_i=01 -> err_o pulse.
- Reset mid-RUN: synchronous rst_i=1 at round 5.
  - Expect all outputs at reset values on the next edge.
  - Expect no valid_o, and a fresh AES-128 block to complete correctly afterwards.
- Abort (AES_CTRL_ABORT_EN): abort_i=1 at round 7.
  - Expect IDLE next cycle with ready_o=1 and no valid_o.
  - abort_i together with valid_i in IDLE -> block accepted normally.
